// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
//   Shared constants and types for the SRAM request arbiter.
//   - ID_INST / ID_DATA : requester IDs held in the in-order ID FIFO
//   - SIZE_B/H/W        : sram_size encodings (byte / half / word)
//   - sram_req_t        : the request fields that travel from a master to mem_*
//   - pick_grant()      : picks a winner among up to two live requesters
// -----------------------------------------------------------------------------
package arb_pkg;

    localparam logic       ID_INST = 1'b0;
    localparam logic       ID_DATA = 1'b1;

    localparam logic [1:0] SIZE_B  = 2'd0;
    localparam logic [1:0] SIZE_H  = 2'd1;
    localparam logic [1:0] SIZE_W  = 2'd2;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } sram_req_t;

    // A lone requester always wins; on a tie the caller-supplied preference wins.
    function automatic logic pick_grant(input logic inst_req, input logic data_req,
                                        input logic prefer);
        if (inst_req && data_req) return prefer;
        return data_req ? ID_DATA : ID_INST;
    endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// -----------------------------------------------------------------------------
// arb_id_fifo
//   1-bit wide, OUTSTANDING-deep FIFO holding the requester ID of every
//   accepted request, in acceptance order. The head names the master that
//   owns the next response.
//   Ports:
//     clk, reset      clock, synchronous active-high reset
//     push, push_id   enqueue an ID (ignored when full)
//     pop             dequeue the head (ignored when empty)
//     head            ID at the head of the queue
//     empty           no entries
//     count           number of entries, 0..OUTSTANDING
// -----------------------------------------------------------------------------
module arb_id_fifo
    import arb_pkg::*;
#(
    parameter int OUTSTANDING = 2,
    parameter int CNT_W       = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             push_id,
    input  logic             pop,
    output logic             head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

    logic             mem_q [OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    // Pointers wrap modulo OUTSTANDING, which need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(OUTSTANDING - 1)) return '0;
        return ptr + 1'b1;
    endfunction

    assign full    = (count_q == CNT_W'(OUTSTANDING));
    assign empty   = (count_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = next_ptr(wr_ptr_q);
        if (pop_ok)  rd_ptr_d = next_ptr(rd_ptr_q);
        // Simultaneous push and pop leaves the count unchanged.
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; an entry is only read after it was written,
    // because count_q (which is reset) gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_id;
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// -----------------------------------------------------------------------------
// sram_req_arbiter
//   Shares one SRAM-like port between the fetch master (inst_sram_*) and the
//   execute master (data_sram_*). The grant is held on a stalled request until
//   the slave accepts it; accepted IDs are queued so in-order responses are
//   routed back to their issuer.
//   Configuration macro:
//     ARB_RR_EN  defined   -> round-robin on ties (last_id register, reset INST)
//                undefined -> fixed priority, data over inst
//   Ports:
//     clk, reset                          clock, synchronous active-high reset
//     inst_sram_req/wr/size/addr/wstrb/wdata   fetch request
//     inst_sram_addr_ok/data_ok/rdata          fetch handshake and response
//     data_sram_*                              same set for the execute master
//     mem_req/wr/size/addr/wstrb/wdata         muxed request to the slave
//     mem_addr_ok, mem_data_ok, mem_rdata      slave handshake and response
//     arb_err                                  sticky: response with no pending ID
// -----------------------------------------------------------------------------
module sram_req_arbiter
    import arb_pkg::*;
#(
    parameter int OUTSTANDING = 2,
    parameter int CNT_W       = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        arb_err
);

    sram_req_t        inst_fields, data_fields, mem_fields;
    logic             grant;
    logic             prefer;
    logic             granted_req;
    logic             accept;
    logic             full;
    logic             fifo_head;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             resp_ok;

    logic             lock_q, lock_d;
    logic             lock_id_q, lock_id_d;
    logic             err_q, err_d;

    assign inst_fields = '{wr: inst_sram_wr, size: inst_sram_size, addr: inst_sram_addr,
                           wstrb: inst_sram_wstrb, wdata: inst_sram_wdata};
    assign data_fields = '{wr: data_sram_wr, size: data_sram_size, addr: data_sram_addr,
                           wstrb: data_sram_wstrb, wdata: data_sram_wdata};

`ifdef ARB_RR_EN
    logic last_id_q, last_id_d;

    // On a tie, the master that was not served last goes first.
    assign prefer    = ~last_id_q;
    assign last_id_d = accept ? grant : last_id_q;

    always_ff @(posedge clk) begin
        if (reset) last_id_q <= ID_INST;
        else       last_id_q <= last_id_d;
    end
`else
    assign prefer = ID_DATA;
`endif

    // full comes from the registered count, so a same-cycle pop cannot open a slot.
    assign full        = (fifo_count == CNT_W'(OUTSTANDING));
    assign mem_req     = ~full & (inst_sram_req | data_sram_req);
    assign grant       = lock_q ? lock_id_q : pick_grant(inst_sram_req, data_sram_req, prefer);
    assign granted_req = (grant == ID_DATA) ? data_sram_req : inst_sram_req;
    assign accept      = mem_req & mem_addr_ok;

    assign mem_fields  = !mem_req          ? '0          :
                         (grant == ID_DATA) ? data_fields : inst_fields;
    assign mem_wr      = mem_fields.wr;
    assign mem_size    = mem_fields.size;
    assign mem_addr    = mem_fields.addr;
    assign mem_wstrb   = mem_fields.wstrb;
    assign mem_wdata   = mem_fields.wdata;

    assign inst_sram_addr_ok = accept & (grant == ID_INST);
    assign data_sram_addr_ok = accept & (grant == ID_DATA);

    // A stalled request pins the grant; if the pinned master drops its request
    // the lock is released on the next edge.
    always_comb begin
        lock_d    = mem_req & ~mem_addr_ok & granted_req;
        lock_id_d = lock_d ? grant : lock_id_q;
        err_d     = err_q | (mem_data_ok & fifo_empty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q    <= 1'b0;
            lock_id_q <= ID_INST;
            err_q     <= 1'b0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            err_q     <= err_d;
        end
    end

    arb_id_fifo #(
        .OUTSTANDING (OUTSTANDING),
        .CNT_W       (CNT_W)
    ) u_id_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (accept),
        .push_id (grant),
        .pop     (mem_data_ok),
        .head    (fifo_head),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // A response with nothing pending is dropped: no pop and no data_ok.
    assign resp_ok           = mem_data_ok & ~fifo_empty;
    assign inst_sram_data_ok = resp_ok & (fifo_head == ID_INST);
    assign data_sram_data_ok = resp_ok & (fifo_head == ID_DATA);
    assign inst_sram_rdata   = inst_sram_data_ok ? mem_rdata : '0;
    assign data_sram_rdata   = data_sram_data_ok ? mem_rdata : '0;
    assign arb_err           = err_q;

endmodule
